// File: rtl/sin_meas.sv
// rtl/sin_meas.sv - period, extremes and amplitude measurement of a periodic unsigned waveform
module sin_meas #(
    parameter int MID        = 128,
    parameter int HYST       = 8,
    parameter int MAX_PERIOD = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] period,
    output logic [7:0]  vmax,
    output logic [7:0]  vmin,
    output logic [7:0]  amp,
    output logic        valid,
    output logic        lock,
    output logic        tmo
);

    localparam logic [7:0]  MID_LVL = 8'(MID);
    localparam logic [7:0]  ARM_LVL = 8'(MID - HYST);
    localparam logic [15:0] CNT_MAX = 16'(MAX_PERIOD);

    typedef enum logic {SEEK, MEAS} state_t;

    state_t      state;
    state_t      state_next;
    logic        armed;
    logic [15:0] cnt;
    logic [7:0]  run_max;
    logic [7:0]  run_min;

    logic        crossing;
    logic        do_start;
    logic        do_latch;
    logic        do_accum;
    logic        do_timeout;

    // A crossing needs a prior dip below the hysteresis level, so ripple near MID never triggers
    assign crossing = en && armed && (din >= MID_LVL);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEEK;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: first crossing starts measuring, a window that reaches CNT_MAX gives up
    always_comb begin
        state_next = state;
        case (state)
            SEEK: if (crossing) state_next = MEAS;
            MEAS: if (en && !crossing && (cnt == CNT_MAX)) state_next = SEEK;
            default: state_next = SEEK;
        endcase
    end

    // Action decode: which datapath update this enabled sample causes
    always_comb begin
        do_start   = 1'b0;
        do_latch   = 1'b0;
        do_accum   = 1'b0;
        do_timeout = 1'b0;
        case (state)
            SEEK: do_start = crossing;
            MEAS: begin
                if (crossing) begin
                    do_latch = 1'b1;
                end else if (en) begin
                    if (cnt == CNT_MAX) do_timeout = 1'b1;
                    else                do_accum   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Arming flag: set by a low sample, consumed by a crossing, dropped on timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (crossing || do_timeout) begin
            armed <= 1'b0;
        end else if (en && (din < ARM_LVL)) begin
            armed <= 1'b1;
        end
    end

    // Window accumulator: the crossing sample opens the next window, cnt saturates via timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 16'd0;
            run_max <= 8'd0;
            run_min <= 8'd0;
        end else if (do_start || do_latch) begin
            cnt     <= 16'd1;
            run_max <= din;
            run_min <= din;
        end else if (do_accum) begin
            cnt <= cnt + 16'd1;
            if (din > run_max) run_max <= din;
            if (din < run_min) run_min <= din;
        end else if (do_timeout) begin
            cnt <= 16'd0;
        end
    end

    // Result registers: latched on a measured crossing, held across timeouts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= 16'd0;
            vmax   <= 8'd0;
            vmin   <= 8'd0;
            amp    <= 8'd0;
            valid  <= 1'b0;
            lock   <= 1'b0;
            tmo    <= 1'b0;
        end else begin
            valid <= do_latch;
            tmo   <= do_timeout;
            if (do_latch) begin
                period <= cnt;
                vmax   <= run_max;
                vmin   <= run_min;
                amp    <= run_max - run_min;
                lock   <= 1'b1;
            end else if (do_timeout) begin
                lock <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sin_meas.sv
// tb/tb_sin_meas.sv - scoreboard bench for sin_meas
module tb_sin_meas;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  din;
    logic [15:0] period;
    logic [7:0]  vmax;
    logic [7:0]  vmin;
    logic [7:0]  amp;
    logic        valid;
    logic        lock;
    logic        tmo;

    sin_meas dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .din    (din),
        .period (period),
        .vmax   (vmax),
        .vmin   (vmin),
        .amp    (amp),
        .valid  (valid),
        .lock   (lock),
        .tmo    (tmo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int per;
        int mx;
        int mn;
    } exp_t;

    exp_t q[$];
    int   cyc            = 0;
    int   n_assert       = 0;
    int   n_fail         = 0;
    int   tmo_due        = -1;
    int   prev_valid_cyc = -1;
    int   last_gap       = -1;
    bit   exp_lock       = 1'b0;
    int   sine_tab[256];
    int   k_cross;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int per, input int mx, input int mn);
        exp_t e;
        e.due = cyc + 1;
        e.per = per;
        e.mx  = mx;
        e.mn  = mn;
        q.push_back(e);
    endtask

    task automatic step(input bit e, input logic [7:0] d);
        exp_t x;
        @(negedge clk);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due == cyc) begin
            x = q.pop_front();
            chk("valid", 32'(valid), 32'd1);
            chk("period", 32'(period), x.per);
            chk("vmax", 32'(vmax), x.mx);
            chk("vmin", 32'(vmin), x.mn);
            chk("amp", 32'(amp), x.mx - x.mn);
            exp_lock = 1'b1;
            if (prev_valid_cyc >= 0) last_gap = cyc - prev_valid_cyc;
            prev_valid_cyc = cyc;
        end else begin
            chk("valid_idle", 32'(valid), 32'd0);
        end
        if (cyc == tmo_due) begin
            chk("tmo", 32'(tmo), 32'd1);
            exp_lock = 1'b0;
        end else begin
            chk("tmo_idle", 32'(tmo), 32'd0);
        end
        chk("lock", 32'(lock), 32'(exp_lock));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_period"}, 32'(period), 32'd0);
        chk({tag, "_vmax"}, 32'(vmax), 32'd0);
        chk({tag, "_vmin"}, 32'(vmin), 32'd0);
        chk({tag, "_amp"}, 32'(amp), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_lock"}, 32'(lock), 32'd0);
        chk({tag, "_tmo"}, 32'(tmo), 32'd0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear before any edge
    task automatic do_reset(input string tag);
        chk({tag, "_pending"}, 32'(q.size()), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_zero(tag);
        exp_lock       = 1'b0;
        prev_valid_cyc = -1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic sq_cycle(input bit first);
        for (int i = 0; i < 10; i++) step(1'b1, 8'd0);
        if (!first) push_exp(20, 200, 0);
        step(1'b1, 8'd200);
        for (int i = 0; i < 9; i++) step(1'b1, 8'd200);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sine_tab[i] = $rtoi(127.5 - 127.5 * $cos(2.0 * 3.14159265358979 * real'(i) / 256.0) + 0.5);
        end
        k_cross = 0;
        for (int i = 255; i >= 0; i--) begin
            if (i <= 128 && sine_tab[i] >= 128) k_cross = i;
        end

        rst = 1'b1;
        en  = 1'b0;
        din = 8'd0;
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // High samples with no prior dip must not start a measurement
        repeat (3) step(1'b1, 8'd200);
        sq_cycle(1'b1);
        repeat (3) sq_cycle(1'b0);

        // 50 disabled cycles inside one window: period unchanged, 70 clocks between valids
        for (int i = 0; i < 5; i++) step(1'b1, 8'd0);
        for (int i = 0; i < 50; i++) step(1'b0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 5; i++) step(1'b1, 8'd0);
        push_exp(20, 200, 0);
        step(1'b1, 8'd200);
        chk("gap_clocks", 32'(last_gap), 32'd70);
        for (int i = 0; i < 9; i++) step(1'b1, 8'd200);
        sq_cycle(1'b0);
        chk("gap_normal", 32'(last_gap), 32'd20);

        // Reset mid-window, then the first crossing only re-enters measurement
        for (int i = 0; i < 5; i++) step(1'b1, 8'd0);
        do_reset("midrst");
        sq_cycle(1'b1);
        sq_cycle(1'b0);
        sq_cycle(1'b0);

        // Ripple around MID never re-arms; timeout at the 65535th sample after the crossing
        tmo_due = cyc + 65526;
        for (int j = 1; j <= 65526; j++) step(1'b1, (j % 2 == 1) ? 8'd125 : 8'd130);
        chk("tmo_hold_period", 32'(period), 32'd20);
        chk("tmo_hold_vmax", 32'(vmax), 32'd200);
        chk("tmo_hold_vmin", 32'(vmin), 32'd0);
        chk("tmo_hold_amp", 32'(amp), 32'd200);
        for (int j = 0; j < 6; j++) step(1'b1, (j % 2 == 0) ? 8'd125 : 8'd130);
        chk("post_tmo_period", 32'(period), 32'd20);

        // Full-scale 256-sample sine
        do_reset("sinrst");
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 256; i++) begin
                if (p > 0 && i == k_cross) push_exp(256, 255, 0);
                step(1'b1, 8'(sine_tab[i]));
            end
        end
        chk("sine_gap", 32'(last_gap), 32'd256);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
